// File: rtl/lcd_bus_reader_if.sv
// Host-side request/result bundle for the LCD read master: request fields in,
// one-cycle oVALID plus held result registers out.
interface lcd_bus_reader_if;
    logic       iREQ;
    logic       iRS;
    logic       iWAIT_BF;
    logic       oREADY;
    logic       oVALID;
    logic [7:0] oDATA;
    logic       oBUSY_FLAG;
    logic [6:0] oADDR;
    logic       oTIMEOUT;

    modport master (
        output iREQ, iRS, iWAIT_BF,
        input  oREADY, oVALID, oDATA, oBUSY_FLAG, oADDR, oTIMEOUT
    );

    modport slave (
        input  iREQ, iRS, iWAIT_BF,
        output oREADY, oVALID, oDATA, oBUSY_FLAG, oADDR, oTIMEOUT
    );
endinterface

// File: rtl/lcd_bus_reader.sv
// Timed HD44780 read-cycle master with optional busy-flag polling; oVALID at accept+CYCLE_CYC+1
// per read (each poll adds CYCLE_CYC); requests are only taken while oREADY=1, never queued.
module lcd_bus_reader #(
    parameter int SETUP_CYC = 4,
    parameter int EN_HI_CYC = 25,
    parameter int HOLD_CYC  = 2,
    parameter int CYCLE_CYC = 50,
    parameter int POLL_MAX  = 1000
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    lcd_bus_reader_if.slave  host,
    output logic             oBUS_REQ,
    inout  wire  [7:0]       LCD_DATA,
    output logic             LCD_RW,
    output logic             LCD_EN,
    output logic             LCD_RS
);
    localparam int CW = $clog2(CYCLE_CYC + 1);
    localparam int PW = $clog2(POLL_MAX + 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LAST    = CW'(SETUP_CYC + EN_HI_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(SETUP_CYC + EN_HI_CYC + HOLD_CYC - 1);
    localparam logic [CW-1:0] CYCLE_LAST = CW'(CYCLE_CYC - 1);
    localparam logic [PW-1:0] POLL_LIMIT = PW'(POLL_MAX);

    typedef enum logic [2:0] {IDLE, SETUP, EN_HI, HOLD, RECOVER, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [PW-1:0]   poll_q, poll_d;
    logic            rs_q, rs_d, wbf_q, wbf_d;
    logic            ready_q, ready_d, valid_q, valid_d, tmo_q, tmo_d;
    logic [7:0]      data_q, data_d;
    logic            bf_q, bf_d;
    logic [6:0]      addr_q, addr_d;
    logic            busreq_q, busreq_d, rw_q, rw_d, en_q, en_d, lcdrs_q, lcdrs_d;
    logic            accept, sample, cycle_end, bf_pending, repoll;

    // Read-only master: the data bus is never driven from here.
    assign LCD_DATA = 8'bz;

    assign accept     = (state_q == IDLE) && host.iREQ;
    assign sample     = (state_q == EN_HI) && (cyc_q == EN_LAST);
    // With no slack after HOLD, RECOVER is skipped and the cycle ends on the last HOLD clock.
    assign cycle_end  = ((state_q == HOLD) && (cyc_q == HOLD_LAST) && (HOLD_LAST == CYCLE_LAST))
                     || ((state_q == RECOVER) && (cyc_q == CYCLE_LAST));
    assign bf_pending = !rs_q && wbf_q && bf_q;
    assign repoll     = bf_pending && ((poll_q + PW'(1)) < POLL_LIMIT);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q  <= IDLE;
            cyc_q    <= '0;
            poll_q   <= '0;
            rs_q     <= 1'b0;
            wbf_q    <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            tmo_q    <= 1'b0;
            data_q   <= '0;
            bf_q     <= 1'b0;
            addr_q   <= '0;
            busreq_q <= 1'b0;
            rw_q     <= 1'b0;
            en_q     <= 1'b0;
            lcdrs_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            poll_q   <= poll_d;
            rs_q     <= rs_d;
            wbf_q    <= wbf_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            tmo_q    <= tmo_d;
            data_q   <= data_d;
            bf_q     <= bf_d;
            addr_q   <= addr_d;
            busreq_q <= busreq_d;
            rw_q     <= rw_d;
            en_q     <= en_d;
            lcdrs_q  <= lcdrs_d;
        end
    end

    // cyc counts clocks since SETUP entry and spans the whole tcycE window.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        poll_d  = poll_q;
        rs_d    = rs_q;
        wbf_d   = wbf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                    cyc_d   = '0;
                    poll_d  = '0;
                    rs_d    = host.iRS;
                    wbf_d   = host.iWAIT_BF;
                end
            end
            SETUP: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == SETUP_LAST) state_d = EN_HI;
            end
            EN_HI: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == EN_LAST) state_d = HOLD;
            end
            HOLD: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == HOLD_LAST) state_d = RECOVER;
            end
            RECOVER: cyc_d = cyc_q + 1'b1;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (cycle_end) begin
            if (repoll) begin
                state_d = SETUP;
                cyc_d   = '0;
                poll_d  = poll_q + 1'b1;
            end else begin
                state_d = DONE;
            end
        end
    end

    // Outputs are registered from the next state so each pin reflects state_q exactly.
    always_comb begin
        rw_d     = state_d inside {SETUP, EN_HI, HOLD};
        en_d     = (state_d == EN_HI);
        lcdrs_d  = rw_d && rs_d;
        busreq_d = state_d inside {SETUP, EN_HI, HOLD, RECOVER};
        ready_d  = (state_d == IDLE);
        valid_d  = (state_d == DONE);
        data_d   = data_q;
        bf_d     = bf_q;
        addr_d   = addr_q;
        tmo_d    = tmo_q;
        if (sample) begin
            data_d = LCD_DATA;
            if (!rs_q) begin
                bf_d   = LCD_DATA[7];
                addr_d = LCD_DATA[6:0];
            end
        end
        if (accept) tmo_d = 1'b0;
        if (cycle_end && bf_pending && !repoll) tmo_d = 1'b1;
    end

    assign host.oREADY     = ready_q;
    assign host.oVALID     = valid_q;
    assign host.oDATA      = data_q;
    assign host.oBUSY_FLAG = bf_q;
    assign host.oADDR      = addr_q;
    assign host.oTIMEOUT   = tmo_q;
    assign oBUS_REQ        = busreq_q;
    assign LCD_RW          = rw_q;
    assign LCD_EN          = en_q;
    assign LCD_RS          = lcdrs_q;
endmodule
